prog_loader: RTL
================

Name: prog_loader

Overview:
- Boot-time writer for the unified program/data memory.
- Receives a length-prefixed little-endian byte stream over a valid/ready interface, assembles 32-bit words, and drives the memory data-port write signals, one word per write strobe.
- Holds the CPU in reset until a load completes, then releases it.
- Sits between the host byte link (UART receiver) and the memory data port; the CPU data port is muxed out while cpu_reset_o is high.

Parameters:
- DEPTH, 1024, memory size in words; the maximum legal word count.
- BASE_ADDR, 0, word address of the first written word.
- TIMEOUT, 100000, idle cycles allowed between bytes once a load has started; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_i  in  1  asynchronous active-high reset
- start_i  in  1  single-cycle pulse that begins a load
- rx_data_i  in  8  stream byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  loader accepts a byte this cycle
- d_addr_o  out  32  memory word address
- d_we_o  out  1  memory write strobe
- d_data_out_o  out  32  memory write data
- busy_o  out  1  load in progress
- done_o  out  1  last load completed successfully
- error_o  out  1  last load aborted
- cpu_reset_o  out  1  CPU hold-in-reset
- word_count_o  out  16  word count N from the current/last header

Behaviour:
- Stream format: byte0 = N[7:0], byte1 = N[15:8], then 4*N data bytes. Each word is little-endian (first byte is bits 7:0).
- Byte transfer occurs on a rising clk when rx_valid_i & rx_ready_o.
- States: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERROR.
- Reset (async, reset_i=1):
  - State = IDLE; counters cleared.
  - rx_ready_o=0, d_we_o=0, d_addr_o=0, d_data_out_o=0.
  - busy_o=0, done_o=0, error_o=0, word_count_o=0, cpu_reset_o=1.
- IDLE/DONE/ERROR: start_i moves to LEN0 and clears done_o, error_o, word index and byte index. start_i is ignored in any other state.
- LEN0: rx_ready_o=1; on transfer, latch N low byte and go to LEN1.
- LEN1: rx_ready_o=1; on transfer, latch N high byte, then:
  - N=0 → DONE.
  - N>DEPTH → ERROR.
  - otherwise → DATA.
- DATA: rx_ready_o=1; shift the byte into the assembly register at lane byte_idx. On the 4th byte (byte_idx=3) go to WRITE.
- WRITE (exactly 1 cycle):
  - rx_ready_o=0, d_we_o=1.
  - d_addr_o = BASE_ADDR + word_idx (zero-extended to 32 bits).
  - d_data_out_o = assembled word.
  - Next cycle: word_idx+1, byte_idx=0; if word_idx+1 == N → DONE, else → DATA.
- d_we_o is high only in WRITE. d_addr_o and d_data_out_o hold their last values otherwise.
- rx_ready_o is 1 only in LEN0, LEN1 and DATA. At most one byte is accepted per cycle, so sustained throughput is 4 bytes per 5 cycles.
- busy_o=1 in LEN0, LEN1, DATA and WRITE.
- done_o=1 in DONE. error_o=1 in ERROR.
- cpu_reset_o=0 only in DONE; 1 in every other state.
- Timeout:
  - Counter is cleared on each accepted byte and on entering LEN1.
  - It counts only in LEN1 and DATA; LEN0 waits indefinitely.
  - Reaching TIMEOUT → ERROR. Any partial word is discarded and not written.
- ERROR: no further writes occur. Already-written words remain in memory. cpu_reset_o stays 1 until a successful load.
- Reset mid-load: returns to IDLE immediately. A write in flight is dropped because d_we_o deasserts asynchronously.
- word_count_o is updated when byte0 and byte1 are latched and holds through DONE/ERROR.

Test Plan:
- Reset, start_i, stream 02 00 78 56 34 12 EF BE AD DE:
  - Writes 0x12345678 @0 and 0xDEADBEEF @1, one d_we_o pulse each.
  - Then done_o=1, cpu_reset_o=0, word_count_o=2.
- Header 00 00 → DONE the cycle after byte1, zero writes, cpu_reset_o=0.
- Header 01 04 (N=1025, exceeds DEPTH=1024) → error_o=1, no d_we_o, rx_ready_o=0, cpu_reset_o=1. A later start_i with a valid 1-word stream → done_o=1.
- TIMEOUT=16, header 01 00 plus 2 data bytes, then 16 idle cycles → error_o=1, no write. Repeat with gaps of 15 cycles → completes normally.
- rx_valid_i held high continuously during a 3-word load:
  - rx_ready_o drops exactly one cycle after every 4th data byte.
  - Addresses are 0, 1, 2 with BASE_ADDR=0 (and 0x100–0x102 with BASE_ADDR=0x100).
- reset_i asserted during the WRITE cycle of word 1 → d_we_o=0 immediately, state IDLE, busy_o=0; start_i while busy (before the reset) ignored.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit
// words, writes them to memory and holds the CPU in reset until a load completes.
module prog_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [31:0] d_addr_o,
    output logic        d_we_o,
    output logic [31:0] d_data_out_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cpu_reset_o,
    output logic [15:0] word_count_o
);

    // state | meaning
    // IDLE  | after reset, waiting for start_i
    // LEN0  | waiting for word count low byte (no timeout)
    // LEN1  | waiting for word count high byte
    // DATA  | collecting the 4 bytes of the current word
    // WRITE | one-cycle memory write strobe
    // DONE  | load complete, CPU released
    // ERROR | load aborted (oversize count or timeout)
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERROR} state_t;

    state_t      state, state_nx;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_lo;
    logic [31:0] timer;
    logic        xfer;
    logic        timed_out;
    logic [15:0] len_full;

    assign xfer      = rx_valid_i & rx_ready_o;
    // Down-counter reloaded on each accepted byte; terminal count 1 means TIMEOUT idle cycles.
    // A TIMEOUT of 0 loads 0, which never reaches the terminal count.
    assign timed_out = !xfer && (timer == 32'd1);
    assign len_full  = {rx_data_i, word_count_o[7:0]};

    assign rx_ready_o  = (state == LEN0) || (state == LEN1) || (state == DATA);
    assign busy_o      = rx_ready_o || (state == WRITE);
    assign d_we_o      = (state == WRITE);
    assign done_o      = (state == DONE);
    assign error_o     = (state == ERROR);
    assign cpu_reset_o = (state != DONE);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERROR: if (start_i) state_nx = LEN0;
            LEN0:  if (xfer) state_nx = LEN1;
            LEN1: begin
                if (xfer) begin
                    if (len_full == 16'd0)                    state_nx = DONE;
                    else if ({16'd0, len_full} > DEPTH)       state_nx = ERROR;
                    else                                      state_nx = DATA;
                end else if (timed_out) begin
                    state_nx = ERROR;
                end
            end
            DATA: begin
                if (xfer && byte_idx == 2'd3) state_nx = WRITE;
                else if (timed_out)           state_nx = ERROR;
            end
            WRITE: state_nx = ((word_idx + 16'd1) == word_count_o) ? DONE : DATA;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            word_idx     <= '0;
            byte_idx     <= '0;
            asm_lo       <= '0;
            timer        <= '0;
            d_addr_o     <= '0;
            d_data_out_o <= '0;
            word_count_o <= '0;
        end else begin
            if (start_i && (state == IDLE || state == DONE || state == ERROR)) begin
                word_idx <= '0;
                byte_idx <= '0;
            end

            if (xfer)
                timer <= TIMEOUT;
            else if ((state == LEN1 || state == DATA) && timer != 32'd0)
                timer <= timer - 32'd1;

            if (xfer && state == LEN0) word_count_o[7:0]  <= rx_data_i;
            if (xfer && state == LEN1) word_count_o[15:8] <= rx_data_i;

            if (xfer && state == DATA) begin
                case (byte_idx)
                    2'd0: asm_lo[7:0]   <= rx_data_i;
                    2'd1: asm_lo[15:8]  <= rx_data_i;
                    2'd2: asm_lo[23:16] <= rx_data_i;
                    2'd3: begin
                        // Address and data are staged here so they are stable throughout WRITE.
                        d_data_out_o <= {rx_data_i, asm_lo};
                        d_addr_o     <= BASE_ADDR + {16'd0, word_idx};
                    end
                    default: ;
                endcase
                byte_idx <= byte_idx + 2'd1;
            end

            if (state == WRITE) begin
                word_idx <= word_idx + 16'd1;
                byte_idx <= '0;
            end
        end
    end

endmodule
